toggle_event_sync: RTL

TOGGLE_EVENT_SYNC -- requirements
Module: toggle_event_sync

---
 rtl/toggle_event_sync_pkg.sv | 13 +
 rtl/toggle_sync_chan.sv | 56 +++++
 rtl/toggle_event_sync.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/toggle_event_sync_pkg.sv
// Shared types and helpers for the toggle event synchroniser.
package toggle_event_sync_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/toggle_sync_chan.sv
// One channel: synchroniser chain, history flop, edge detect, pending counter.
// Lost-event output exists only with TOGGLE_EVENT_SYNC_OVERFLOW_EN.
module toggle_sync_chan #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             armed,
  input  logic             toggle,
  input  logic             dec,
  output logic             level,
  output logic [CNT_W-1:0] cnt
`ifdef TOGGLE_EVENT_SYNC_OVERFLOW_EN
  ,
  output logic             lost
`endif
);

  logic [STAGES-1:0] sync;
  logic              hist;
  logic              evt;
  logic              sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], toggle};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign evt   = armed && (sync[STAGES-1] ^ hist);
  assign sat   = &cnt;

  // Simultaneous event and accept cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({evt, dec})
        2'b10:   if (!sat) cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef TOGGLE_EVENT_SYNC_OVERFLOW_EN
  assign lost = evt && !dec && sat;
`endif

endmodule

// File: rtl/toggle_event_sync.sv
// Multi-channel toggle event synchroniser with round-robin event output.
// Define TOGGLE_EVENT_SYNC_OVERFLOW_EN for sticky per-channel overflow flags.
module toggle_event_sync
  import toggle_event_sync_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 3,
  parameter int CNT_W    = 3
) (
  input  logic                              clkDst,
  input  logic                              rst,
  input  logic [CHANNELS-1:0]               toggle_in,
  output logic [CHANNELS-1:0]               level_out,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [chan_w(CHANNELS)-1:0]       evt_chan,
  output logic                              pending_any
`ifdef TOGGLE_EVENT_SYNC_OVERFLOW_EN
  ,
  input  logic                              overflow_clr,
  output logic [CHANNELS-1:0]               overflow
`endif
);

  localparam int CW   = chan_w(CHANNELS);
  localparam int WARM = STAGES + 1;
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  logic [2:0]          warm;
  logic                armed;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] nz;
  logic [CHANNELS-1:0] nz_after;
  logic [CHANNELS-1:0] dec;
  logic                accept;
  state_t              state, state_n;
  logic [CW-1:0]       chan_n;
  logic [CW-1:0]       ptr, ptr_n;
  logic [CW-1:0]       nxt;

  // Edge detection stays masked until the chain has settled after reset.
  always_ff @(posedge clkDst or posedge rst) begin
    if (rst) warm <= '0;
    else if (!armed) warm <= warm + 3'd1;
  end

  assign armed = (warm == 3'(WARM));

`ifdef TOGGLE_EVENT_SYNC_OVERFLOW_EN
  logic [CHANNELS-1:0] lost;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign dec[g] = accept && (evt_chan == CW'(g));
    assign nz[g]  = |cnt[g];

    toggle_sync_chan #(
      .STAGES (STAGES),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk    (clkDst),
      .rst    (rst),
      .armed  (armed),
      .toggle (toggle_in[g]),
      .dec    (dec[g]),
      .level  (level_out[g]),
      .cnt    (cnt[g])
`ifdef TOGGLE_EVENT_SYNC_OVERFLOW_EN
      ,
      .lost   (lost[g])
`endif
    );
  end

  assign evt_valid = (state == PRESENT);
  assign accept    = evt_valid && evt_ready;
  assign nxt       = (evt_chan == LAST) ? '0 : evt_chan + 1'b1;

  always_comb begin
    nz_after = nz;
    if (accept && cnt[evt_chan] == CNT_W'(1))
      nz_after[evt_chan] = 1'b0;
  end

  function automatic logic [CW-1:0] rr_pick(
    input logic [CHANNELS-1:0] req,
    input logic [CW-1:0]       start
  );
    logic [CW:0]   sum;
    logic [CW-1:0] idx;
    logic          found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum = {1'b0, start} + (CW+1)'(i);
      if (sum >= (CW+1)'(CHANNELS))
        sum = sum - (CW+1)'(CHANNELS);
      idx = sum[CW-1:0];
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_n = state;
    chan_n  = evt_chan;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (|nz) begin
          state_n = PRESENT;
          chan_n  = rr_pick(nz, ptr);
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          ptr_n = nxt;
          if (|nz_after) chan_n = rr_pick(nz_after, nxt);
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkDst or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      evt_chan    <= '0;
      ptr         <= '0;
      pending_any <= 1'b0;
    end else begin
      state       <= state_n;
      evt_chan    <= chan_n;
      ptr         <= ptr_n;
      pending_any <= |nz;
    end
  end

`ifdef TOGGLE_EVENT_SYNC_OVERFLOW_EN
  // A new loss wins over a clear in the same cycle.
  always_ff @(posedge clkDst or posedge rst) begin
    if (rst) overflow <= '0;
    else overflow <= lost | (overflow & ~{CHANNELS{overflow_clr}});
  end
`endif

endmodule
